// File: rtl/vga_timing_pkg.sv
// Shared timing defaults, monitor state encoding and error-bit positions for
// the VGA timing monitor.
package vga_timing_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 24;
    localparam int DEF_H_SYNC   = 40;
    localparam int DEF_H_BP     = 128;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 9;
    localparam int DEF_V_SYNC   = 3;
    localparam int DEF_V_BP     = 28;

    localparam int H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam int                CNT_W   = 10;
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_ALIGN  = 2'd1,
        ST_LOCKED = 2'd2
    } mon_state_t;

    localparam int ERR_RGB_BLANK   = 0;
    localparam int ERR_LINE_LEN    = 1;
    localparam int ERR_HSYNC_WIDTH = 2;
    localparam int ERR_FRAME_LEN   = 3;

    // Position counters park at the top value instead of wrapping, so a
    // missing sync can never alias back into a plausible position.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// Registers one active-low sync input and flags its falling and rising edges
// as seen on the registered copy.
module vga_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic sync_in,
    output logic sync_r,
    output logic fall,
    output logic rise
);

    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        sync_d = sync_in;
        prev_d = sync_q;
    end

    // Idle (high) after reset so no edge is reported before real activity.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign sync_r = sync_q;
    assign fall   = ~sync_q & prev_q;
    assign rise   = sync_q & ~prev_q;

endmodule

// File: rtl/vga_timing_monitor.sv
// Recovers pixel position from incoming hsync/vsync, locks onto timing that
// matches the parameters, and reports visible pixels plus sticky timing errors.
module vga_timing_monitor
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [2:0]  rgb,
    input  logic        err_clear,
    output logic        pix_valid,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic [2:0]  pix_rgb,
    output logic        frame_start,
    output logic        locked,
    output logic [3:0]  err,
    output logic [15:0] frame_count
);

    localparam logic [10:0]      LINE_CLKS   = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam logic [10:0]      FRAME_LINES = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam logic [10:0]      HSYNC_CLKS  = 11'(H_SYNC);
    localparam logic [CNT_W-1:0] H_START     = CNT_W'(H_SYNC + H_BP);
    localparam logic [CNT_W-1:0] H_LAST      = CNT_W'(H_SYNC + H_BP + H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] V_START     = CNT_W'(V_SYNC + V_BP);
    localparam logic [CNT_W-1:0] V_LAST      = CNT_W'(V_SYNC + V_BP + V_ACTIVE - 1);

    logic hs_r, hs_fall, hs_rise;
    logic vs_r, vs_fall, vs_rise;
    logic unused_vs_edges;

    vga_sync_edge u_hs_edge (
        .clk     (clk),
        .reset   (reset),
        .sync_in (hsync),
        .sync_r  (hs_r),
        .fall    (hs_fall),
        .rise    (hs_rise)
    );

    vga_sync_edge u_vs_edge (
        .clk     (clk),
        .reset   (reset),
        .sync_in (vsync),
        .sync_r  (vs_r),
        .fall    (vs_fall),
        .rise    (vs_rise)
    );

    // Frame boundaries are qualified at hsync edges, so raw vsync pulses are not needed.
    assign unused_vs_edges = vs_fall ^ vs_rise;

    logic [2:0]       rgb_r_q, rgb_r_d;
    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
    logic             vs_hi_q, vs_hi_d;
    logic             align_bad_q, align_bad_d;
    mon_state_t       state_q, state_d;
    logic             pix_valid_q, pix_valid_d;
    logic [9:0]       pix_x_q, pix_x_d;
    logic [9:0]       pix_y_q, pix_y_d;
    logic [2:0]       pix_rgb_q, pix_rgb_d;
    logic             frame_start_q, frame_start_d;
    logic             locked_q, locked_d;
    logic [3:0]       err_q, err_d;
    logic [15:0]      frame_count_q, frame_count_d;

    logic       frame_edge, visible;
    logic       line_bad, width_bad, frame_bad;
    logic [3:0] err_new;

    // h_cnt_d / v_cnt_d are the position of the sample currently in rgb_r_q.
    always_comb begin
        rgb_r_d    = rgb;
        frame_edge = hs_fall && !vs_r && vs_hi_q;
        h_cnt_d    = hs_fall ? '0 : sat_inc(h_cnt_q);
        v_cnt_d    = v_cnt_q;
        vs_hi_d    = vs_hi_q;
        if (hs_fall) begin
            v_cnt_d = frame_edge ? '0 : sat_inc(v_cnt_q);
            vs_hi_d = vs_r;
        end
        visible   = (h_cnt_d >= H_START) && (h_cnt_d <= H_LAST) &&
                    (v_cnt_d >= V_START) && (v_cnt_d <= V_LAST);
        line_bad  = hs_fall    && (({1'b0, h_cnt_q} + 11'd1) != LINE_CLKS);
        width_bad = hs_rise    && (({1'b0, h_cnt_q} + 11'd1) != HSYNC_CLKS);
        frame_bad = frame_edge && (({1'b0, v_cnt_q} + 11'd1) != FRAME_LINES);
    end

    always_comb begin
        state_d     = state_q;
        align_bad_d = align_bad_q;
        case (state_q)
            ST_SEARCH: begin
                if (frame_edge) begin
                    state_d     = ST_ALIGN;
                    align_bad_d = 1'b0;
                end
            end
            ST_ALIGN: begin
                if (line_bad || width_bad) begin
                    align_bad_d = 1'b1;
                end
                if (frame_edge) begin
                    state_d = (!align_bad_q && !line_bad && !frame_bad) ? ST_LOCKED : ST_SEARCH;
                end
            end
            ST_LOCKED: begin
                if (line_bad || frame_bad) begin
                    state_d = ST_SEARCH;
                end
            end
            default: state_d = ST_SEARCH;
        endcase
    end

    always_comb begin
        err_new                  = '0;
        err_new[ERR_RGB_BLANK]   = (rgb_r_q != 3'b000) &&
                                   (!hs_r || !vs_r || ((state_q == ST_LOCKED) && !visible));
        err_new[ERR_LINE_LEN]    = (state_q != ST_SEARCH) && line_bad;
        err_new[ERR_HSYNC_WIDTH] = (state_q != ST_SEARCH) && width_bad;
        err_new[ERR_FRAME_LEN]   = (state_q != ST_SEARCH) && frame_bad;
        // A fresh error wins over a simultaneous clear.
        err_d         = (err_clear ? 4'b0000 : err_q) | err_new;
        frame_count_d = frame_count_q + ((frame_edge && (state_q == ST_LOCKED)) ? 16'd1 : 16'd0);
        pix_valid_d   = (state_q == ST_LOCKED) && visible;
        pix_x_d       = visible ? (h_cnt_d - H_START) : '0;
        pix_y_d       = visible ? (v_cnt_d - V_START) : '0;
        pix_rgb_d     = rgb_r_q;
        frame_start_d = frame_edge;
        locked_d      = (state_d == ST_LOCKED);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_r_q       <= '0;
            h_cnt_q       <= CNT_MAX;
            v_cnt_q       <= CNT_MAX;
            vs_hi_q       <= 1'b0;
            align_bad_q   <= 1'b0;
            state_q       <= ST_SEARCH;
            pix_valid_q   <= 1'b0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            pix_rgb_q     <= '0;
            frame_start_q <= 1'b0;
            locked_q      <= 1'b0;
            err_q         <= '0;
            frame_count_q <= '0;
        end else begin
            rgb_r_q       <= rgb_r_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            vs_hi_q       <= vs_hi_d;
            align_bad_q   <= align_bad_d;
            state_q       <= state_d;
            pix_valid_q   <= pix_valid_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            pix_rgb_q     <= pix_rgb_d;
            frame_start_q <= frame_start_d;
            locked_q      <= locked_d;
            err_q         <= err_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign pix_valid   = pix_valid_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign pix_rgb     = pix_rgb_q;
    assign frame_start = frame_start_q;
    assign locked      = locked_q;
    assign err         = err_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Directed bench for vga_timing_monitor using a reduced 32x15 raster so that
// many complete frames fit in a short run.
module tb_vga_timing_monitor;

    localparam int HA = 16, HF = 4, HS = 6, HB = 6;
    localparam int VA = 8,  VF = 2, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int HX0 = HS + HB;
    localparam int VY0 = VS + VB;

    logic        clk = 1'b0;
    logic        reset, hsync, vsync, err_clear;
    logic [2:0]  rgb;
    logic        pix_valid, frame_start, locked;
    logic [9:0]  pix_x, pix_y;
    logic [2:0]  pix_rgb;
    logic [3:0]  err;
    logic [15:0] frame_count;

    int tests = 0;
    int fails = 0;
    int edge_cnt = 0;
    int pv_count = 0;
    int fs_count = 0;
    int locked_fall_edge = -1;
    logic locked_prev = 1'b0;
    int probe_edge = -100;
    int mark_edge = -100;
    bit probe_frame = 1'b0;
    int pv0, fs0;

    vga_timing_monitor #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .hsync       (hsync),
        .vsync       (vsync),
        .rgb         (rgb),
        .err_clear   (err_clear),
        .pix_valid   (pix_valid),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_rgb     (pix_rgb),
        .frame_start (frame_start),
        .locked      (locked),
        .err         (err),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    always @(negedge clk) begin
        if (pix_valid) pv_count++;
        if (frame_start) fs_count++;
        if (locked_prev && !locked) locked_fall_edge = edge_cnt;
        locked_prev = locked;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] pat(input int x, input int y);
        return 3'(7 - ((x + y) % 8));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string pfx);
        check_eq({pfx, "_pix_valid"},   pix_valid,   0);
        check_eq({pfx, "_pix_x"},       pix_x,       0);
        check_eq({pfx, "_pix_y"},       pix_y,       0);
        check_eq({pfx, "_pix_rgb"},     pix_rgb,     0);
        check_eq({pfx, "_frame_start"}, frame_start, 0);
        check_eq({pfx, "_locked"},      locked,      0);
        check_eq({pfx, "_err"},         err,         0);
        check_eq({pfx, "_frame_count"}, frame_count, 0);
    endtask

    task automatic hold_reset(input string pfx);
        reset = 1'b1; hsync = 1'b1; vsync = 1'b1; rgb = 3'b000; err_clear = 1'b0;
        repeat (3) tick();
        check_all_zero(pfx);
        reset = 1'b0;
    endtask

    // Drives lines [first, n_lines) of a frame; optional one-line anomalies.
    task automatic send_frame(input int first, input int n_lines, input int long_line,
                              input int wide_line, input int dirty_line, input int clr_line);
        for (int l = first; l < n_lines; l++) begin
            int len, hsw;
            len = HT + ((l == long_line) ? 1 : 0);
            hsw = HS + ((l == wide_line) ? 1 : 0);
            for (int c = 0; c < len; c++) begin
                logic [2:0] px;
                bit vis;
                if (edge_cnt == probe_edge + 1) begin
                    check_eq("origin_prev_pix_valid", pix_valid, 0);
                end
                if (edge_cnt == probe_edge + 2) begin
                    check_eq("origin_pix_valid", pix_valid, 1);
                    check_eq("origin_pix_x",     pix_x,     0);
                    check_eq("origin_pix_y",     pix_y,     0);
                    check_eq("origin_pix_rgb",   pix_rgb,   3'b111);
                end
                vis = (c >= HX0) && (c < HX0 + HA) && (l >= VY0) && (l < VY0 + VA);
                px  = vis ? pat(c - HX0, l - VY0) : 3'b000;
                if (l == dirty_line && c == 1) px = 3'b101;
                if (probe_frame && vis && c == HX0 && l == VY0) probe_edge = edge_cnt;
                if (long_line >= 0 && l == long_line + 1 && c == 0) mark_edge = edge_cnt;
                hsync     = (c < hsw) ? 1'b0 : 1'b1;
                vsync     = (l < VS) ? 1'b0 : 1'b1;
                rgb       = px;
                err_clear = (l == clr_line && c == 2);
                tick();
            end
        end
    endtask

    initial begin
        hold_reset("por");

        send_frame(VT - 2, VT, -1, -1, -1, -1);
        fs0 = fs_count;
        send_frame(0, VT, -1, -1, -1, -1);
        check_eq("f1_locked", locked, 0);
        check_eq("f1_frame_starts", fs_count - fs0, 1);

        pv0 = pv_count;
        send_frame(0, VT, -1, -1, -1, -1);
        check_eq("f2_locked", locked, 1);
        check_eq("f2_err", err, 0);
        check_eq("f2_pix_count", pv_count - pv0, HA * VA);
        check_eq("f2_frame_count", frame_count, 0);

        probe_frame = 1'b1;
        pv0 = pv_count;
        send_frame(0, VT, -1, -1, -1, -1);
        probe_frame = 1'b0;
        check_eq("f3_frame_count", frame_count, 1);
        check_eq("f3_pix_count", pv_count - pv0, HA * VA);
        check_eq("f3_frame_starts", fs_count - fs0, 3);
        check_eq("f3_err", err, 0);

        send_frame(0, VT, 6, -1, -1, -1);
        check_eq("long_line_err", err, 4'b0010);
        check_eq("long_line_locked", locked, 0);
        check_eq("long_line_drop_edge", locked_fall_edge, mark_edge + 2);

        pv0 = pv_count;
        send_frame(0, VT, -1, -1, -1, 3);
        check_eq("relock_align_locked", locked, 0);
        check_eq("relock_align_err", err, 0);
        check_eq("relock_align_pix_count", pv_count - pv0, 0);
        send_frame(0, VT, -1, -1, -1, -1);
        check_eq("relock_locked", locked, 1);
        check_eq("relock_frame_count", frame_count, 2);

        send_frame(0, VT, -1, -1, 8, 8);
        check_eq("rgb_blank_err_vs_clear", err, 4'b0001);
        check_eq("rgb_blank_locked", locked, 1);
        send_frame(0, VT, -1, -1, -1, 3);
        check_eq("err_clear_err", err, 0);

        send_frame(0, VT, -1, 4, -1, -1);
        check_eq("hsync_width_err", err, 4'b0100);
        check_eq("hsync_width_locked", locked, 1);
        send_frame(0, VT, -1, -1, -1, 3);
        check_eq("hsync_width_cleared", err, 0);
        check_eq("pre_long_frame_count", frame_count, 6);

        send_frame(0, VT + 1, -1, -1, -1, -1);
        check_eq("long_frame_pending_err", err, 0);
        check_eq("long_frame_pending_locked", locked, 1);
        send_frame(0, 6, -1, -1, -1, -1);
        check_eq("frame_len_err", err, 4'b1000);
        check_eq("frame_len_locked", locked, 0);
        check_eq("frame_len_frame_count", frame_count, 8);

        hold_reset("midreset");
        send_frame(6, VT, -1, -1, -1, -1);
        send_frame(0, VT, -1, -1, -1, -1);
        check_eq("post_reset_align_locked", locked, 0);
        send_frame(0, VT, -1, -1, -1, -1);
        check_eq("post_reset_locked", locked, 1);
        check_eq("post_reset_err", err, 0);
        check_eq("post_reset_frame_count", frame_count, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vga_timing_monitor.md
VGA_TIMING_MONITOR -- requirements
Module: vga_timing_monitor

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  H_ACTIVE  640  visible pixels per line
  H_FP      24   horizontal front porch, clocks
  H_SYNC    40   hsync low width, clocks
  H_BP      128  horizontal back porch, clocks (H_TOTAL = 832)
  V_ACTIVE  480  visible lines per frame
  V_FP      9    vertical front porch, lines
  V_SYNC    3    vsync low width, lines
  V_BP      28   vertical back porch, lines (V_TOTAL = 520)
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clk          in   1   pixel clock, single clock domain
  reset        in   1   synchronous, active-high
  hsync        in   1   horizontal sync, active low
  vsync        in   1   vertical sync, active low
  rgb          in   3   pixel colour
  err_clear    in   1   clears sticky error flags
  pix_valid    out  1   pix_* carries a visible pixel
  pix_x        out  10  visible column, 0..H_ACTIVE-1
  pix_y        out  10  visible row, 0..V_ACTIVE-1
  pix_rgb      out  3   captured colour
  frame_start  out  1   one-cycle pulse at each vsync falling edge
  locked       out  1   timing recovered and matching parameters
  err          out  4   sticky errors [0] rgb-in-blank, [1] line length, [2] hsync width, [3] frame length
  frame_count  out  16  frames seen while locked

Function
REQ-003 hsync, vsync and rgb SHALL be registered once; all decisions SHALL use the registered copies (hs_r, vs_r, rgb_r).
REQ-004 An hsync falling edge (hs_r low, previous hs_r high) SHALL set h_cnt to 0; otherwise h_cnt SHALL increment, saturating at 1023.
REQ-005 On each hsync falling edge v_cnt SHALL increment, saturating at 1023; if vs_r is low and was high at the previous hsync edge, v_cnt SHALL instead be set to 0 and frame_start pulsed for that cycle.
REQ-006 A visible pixel SHALL be h_cnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE-1] = [168,807] and v_cnt in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE-1] = [31,510].
REQ-007 pix_valid SHALL be high only in LOCKED for visible pixels; pix_x/pix_y SHALL be the counters minus their window start; latency rgb pin to pix_rgb SHALL be exactly 2 cycles.
REQ-008 FSM states SEARCH, ALIGN, LOCKED: SEARCH->ALIGN on frame_start; ALIGN->LOCKED on next frame_start if all lines in that frame measured H_TOTAL, every hsync low H_SYNC and frame V_TOTAL, else ALIGN->SEARCH; LOCKED->SEARCH on any line-length or frame-length mismatch.
REQ-009 locked SHALL equal (state==LOCKED), registered; it SHALL drop the cycle after the mismatching edge.
REQ-010 err[1] SHALL set when h_cnt+1 != H_TOTAL at an hsync falling edge; err[2] when hsync low duration != H_SYNC at its rising edge; err[3] when lines since last frame_start != V_TOTAL at frame_start; all only in ALIGN or LOCKED.
REQ-011 err[0] SHALL set when rgb_r != 0 while hs_r or vs_r is low (any state), or outside the visible window in LOCKED.
REQ-012 err bits SHALL be sticky; err_clear SHALL zero them next cycle; an error detected in the same cycle as err_clear SHALL remain set.
REQ-013 frame_count SHALL increment on frame_start while LOCKED, wrapping 0xFFFF->0.

Reset
REQ-014 reset SHALL force state SEARCH, h_cnt=v_cnt=1023 (saturated), and all outputs 0: pix_valid, pix_x, pix_y, pix_rgb, frame_start, locked, err, frame_count.
REQ-015 reset mid-frame SHALL discard alignment; relock SHALL require one full error-free frame after the next frame_start.

Structure
REQ-016 Package vga_timing_pkg SHALL hold default timing constants, H_TOTAL/V_TOTAL, the FSM state enum and err bit indices.
REQ-017 One sub-module vga_sync_edge SHALL implement input registration and falling/rising edge detection, instantiated for hsync and vsync.

Verification
REQ-018 Clean 832x520 source, 3 frames -> locked high after 2nd frame_start, err=0, 307200 pix_valid per locked frame, frame_count=1 at third frame_start.
REQ-019 Locked, one line lengthened to 833 -> err[1]=1, locked low next cycle, relock after one clean frame.
REQ-020 rgb=3'b101 driven during hsync low -> err[0]=1; err_clear pulse -> err=0.
REQ-021 hsync low 41 clocks once -> err[2]=1, locked stays high.
REQ-022 Frame of 521 lines -> err[3]=1 at frame_start, state SEARCH; reset asserted mid-frame -> all outputs 0, locked only after a further full clean frame.
REQ-023 Pixel at x=0,y=0 with rgb=3'b111 -> pix_rgb=3'b111, pix_x=0, pix_y=0 exactly 2 cycles after input.
